// File: rtl/i2c_shift_reg_if.sv
// Control-side bundle between the I2C control FSM (master) and the byte shifter (slave).
// The SCL/SDA pad signals stay as plain ports on the shifter.
interface i2c_shift_reg_if;
    logic       i_shift_load;
    logic       i_shift_en;
    logic       i_rw_mode;
    logic [7:0] i_tx_data;
    logic       i_ack_en;
    logic [7:0] o_rx_data;
    logic       o_shift_done;
    logic       o_ack_received;
    logic       o_busy;
    logic [3:0] o_bit_cnt;

    modport master (
        output i_shift_load, i_shift_en, i_rw_mode, i_tx_data, i_ack_en,
        input  o_rx_data, o_shift_done, o_ack_received, o_busy, o_bit_cnt
    );

    modport slave (
        input  i_shift_load, i_shift_en, i_rw_mode, i_tx_data, i_ack_en,
        output o_rx_data, o_shift_done, o_ack_received, o_busy, o_bit_cnt
    );
endinterface

// File: rtl/i2c_shift_reg.sv
// I2C byte shifter: moves 8 data bits plus the ACK bit between the control FSM and the
// SDA pad, paced by synchronized SCL edges. Works for master and slave since SCL is only followed.
module i2c_shift_reg #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    i2c_shift_reg_if.slave        ctrl,
    input  logic                  i_scl_in,
    input  logic                  i_sda_in,
    output logic                  o_sda_out,
    output logic                  o_sda_oe
);

    typedef enum logic [1:0] {StIdle, StData, StAck} state_e;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_dly;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_rise;
    logic                   w_scl_fall;

    state_e     r_state,      w_state_d;
    logic [7:0] r_shreg,      w_shreg_d;
    logic       r_rx_mode,    w_rx_mode_d;
    logic [3:0] r_bit_cnt,    w_bit_cnt_d;
    logic       r_sda_out,    w_sda_out_d;
    logic       r_sda_oe,     w_sda_oe_d;
    logic [7:0] r_rx_data,    w_rx_data_d;
    logic       r_done,       w_done_d;
    logic       r_ack_rcv,    w_ack_rcv_d;
    logic       r_busy,       w_busy_d;
    logic       r_ack_sample, w_ack_sample_d;

    // Synchronizers idle high so reset never looks like a bus edge towards the FSM.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_dly  <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda_in};
            r_scl_dly  <= r_scl_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_dly;
    assign w_scl_fall = ~w_scl_s & r_scl_dly;

    always_comb begin
        w_state_d      = r_state;
        w_shreg_d      = r_shreg;
        w_rx_mode_d    = r_rx_mode;
        w_bit_cnt_d    = r_bit_cnt;
        w_sda_out_d    = r_sda_out;
        w_sda_oe_d     = r_sda_oe;
        w_rx_data_d    = r_rx_data;
        w_done_d       = 1'b0;
        w_ack_rcv_d    = r_ack_rcv;
        w_busy_d       = r_busy;
        w_ack_sample_d = r_ack_sample;

        unique case (r_state)
            StIdle: begin
                if (ctrl.i_shift_load && ctrl.i_shift_en) begin
                    w_state_d      = StData;
                    w_rx_mode_d    = ctrl.i_rw_mode;
                    w_bit_cnt_d    = 4'd0;
                    w_busy_d       = 1'b1;
                    w_ack_sample_d = 1'b0;
                    if (ctrl.i_rw_mode) begin
                        w_sda_oe_d  = 1'b0;
                        w_sda_out_d = 1'b1;
                    end else begin
                        w_shreg_d   = ctrl.i_tx_data;
                        w_sda_out_d = ctrl.i_tx_data[7];
                        w_sda_oe_d  = 1'b1;
                    end
                end
            end

            StData: begin
                if (!ctrl.i_shift_en) begin
                    w_state_d   = StIdle;
                    w_sda_oe_d  = 1'b0;
                    w_sda_out_d = 1'b1;
                    w_busy_d    = 1'b0;
                    w_bit_cnt_d = 4'd0;
                end else if (w_scl_rise) begin
                    if (r_rx_mode) begin
                        w_shreg_d = {r_shreg[6:0], w_sda_s};
                    end
                end else if (w_scl_fall) begin
                    w_bit_cnt_d = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_d = StAck;
                        if (r_rx_mode) begin
                            w_sda_out_d = ~ctrl.i_ack_en;
                            w_sda_oe_d  = 1'b1;
                        end else begin
                            w_sda_out_d = 1'b1;
                            w_sda_oe_d  = 1'b0;
                        end
                    end else if (!r_rx_mode) begin
                        w_shreg_d   = {r_shreg[6:0], 1'b0};
                        w_sda_out_d = r_shreg[6];
                    end
                end
            end

            StAck: begin
                if (!ctrl.i_shift_en) begin
                    w_state_d   = StIdle;
                    w_sda_oe_d  = 1'b0;
                    w_sda_out_d = 1'b1;
                    w_busy_d    = 1'b0;
                    w_bit_cnt_d = 4'd0;
                end else if (w_scl_rise) begin
                    w_ack_sample_d = ~w_sda_s;
                end else if (w_scl_fall) begin
                    w_state_d   = StIdle;
                    w_bit_cnt_d = 4'd8;
                    w_sda_oe_d  = 1'b0;
                    w_sda_out_d = 1'b1;
                    w_done_d    = 1'b1;
                    w_ack_rcv_d = r_ack_sample;
                    w_busy_d    = 1'b0;
                    if (r_rx_mode) begin
                        w_rx_data_d = r_shreg;
                    end
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_shreg      <= 8'h00;
            r_rx_mode    <= 1'b0;
            r_bit_cnt    <= 4'd0;
            r_sda_out    <= 1'b1;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 8'h00;
            r_done       <= 1'b0;
            r_ack_rcv    <= 1'b0;
            r_busy       <= 1'b0;
            r_ack_sample <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_shreg      <= w_shreg_d;
            r_rx_mode    <= w_rx_mode_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_sda_out    <= w_sda_out_d;
            r_sda_oe     <= w_sda_oe_d;
            r_rx_data    <= w_rx_data_d;
            r_done       <= w_done_d;
            r_ack_rcv    <= w_ack_rcv_d;
            r_busy       <= w_busy_d;
            r_ack_sample <= w_ack_sample_d;
        end
    end

    assign o_sda_out           = r_sda_out;
    assign o_sda_oe            = r_sda_oe;
    assign ctrl.o_rx_data      = r_rx_data;
    assign ctrl.o_shift_done   = r_done;
    assign ctrl.o_ack_received = r_ack_rcv;
    assign ctrl.o_busy         = r_busy;
    assign ctrl.o_bit_cnt      = r_bit_cnt;

endmodule

// File: tb/tb_i2c_shift_reg.sv
// Directed bench for i2c_shift_reg: drives SCL and an open-drain SDA bus, checks the
// shifter's bus bits, ACK handling, done pulses, aborts and reset against hand-computed values.
module tb_i2c_shift_reg;

    logic clk;
    logic rst_n;
    logic scl;
    logic slave_sda;
    logic sda_out;
    logic sda_oe;
    wire  sda_line;

    int n_checks;
    int n_errors;
    int n_done;
    logic busy_at_done;

    i2c_shift_reg_if u_if ();

    i2c_shift_reg #(
        .SYNC_STAGES (2)
    ) u_dut (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .ctrl      (u_if),
        .i_scl_in  (scl),
        .i_sda_in  (sda_line),
        .o_sda_out (sda_out),
        .o_sda_oe  (sda_oe)
    );

    // Open-drain bus: either side can only pull low.
    assign sda_line = (sda_oe ? sda_out : 1'b1) & slave_sda;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.o_shift_done) begin
            n_done++;
            busy_at_done = u_if.o_busy;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_byte(input logic rw, input logic [7:0] tx);
        @(negedge clk);
        u_if.i_shift_load = 1'b1;
        u_if.i_rw_mode    = rw;
        u_if.i_tx_data    = tx;
        @(negedge clk);
        u_if.i_shift_load = 1'b0;
    endtask

    // One transfer of n_bits SCL pulses; seen[8] is the first bit on the bus, seen[0] the ACK bit.
    task automatic run_byte(input logic rw, input logic [7:0] tx, input logic ack_en,
                            input logic [7:0] slave_data, input logic slave_ack,
                            input int n_bits, input bit inject,
                            output logic [8:0] seen, output logic oe9, output logic out9);
        seen = '0;
        oe9  = 1'b0;
        out9 = 1'b0;
        u_if.i_ack_en = ack_en;
        load_byte(rw, tx);
        for (int i = 0; i < n_bits; i++) begin
            if (i < 8) slave_sda = rw ? slave_data[7-i] : 1'b1;
            else       slave_sda = rw ? 1'b1 : slave_ack;
            repeat (4) @(negedge clk);
            if (inject && i == 3) begin
                check_eq("cnt_before_reload", 32'(u_if.o_bit_cnt), 32'd3);
                load_byte(1'b0, 8'h00);
            end
            repeat (4) @(negedge clk);
            scl = 1'b1;
            repeat (5) @(negedge clk);
            seen[8-i] = sda_line;
            if (i == 8) begin
                oe9  = sda_oe;
                out9 = sda_out;
            end
            repeat (3) @(negedge clk);
            scl = 1'b0;
            repeat (5) @(negedge clk);
        end
        slave_sda = 1'b1;
    endtask

    logic [8:0] seen;
    logic       oe9;
    logic       out9;
    int         base;

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_done   = 0;
        busy_at_done = 1'b1;
        rst_n     = 1'b0;
        scl       = 1'b1;
        slave_sda = 1'b1;
        u_if.i_shift_load = 1'b0;
        u_if.i_shift_en   = 1'b1;
        u_if.i_rw_mode    = 1'b0;
        u_if.i_tx_data    = 8'h00;
        u_if.i_ack_en     = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_sda_out", 32'(sda_out), 32'd1);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_rx_data", 32'(u_if.o_rx_data), 32'h00);
        check_eq("rst_done", 32'(u_if.o_shift_done), 32'd0);
        check_eq("rst_ack", 32'(u_if.o_ack_received), 32'd0);
        check_eq("rst_busy", 32'(u_if.o_busy), 32'd0);
        check_eq("rst_cnt", 32'(u_if.o_bit_cnt), 32'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        scl = 1'b0;
        repeat (6) @(negedge clk);

        // TX 0xA5, slave ACKs
        base = n_done;
        u_if.i_ack_en = 1'b0;
        load_byte(1'b0, 8'hA5);
        check_eq("a5_busy_after_load", 32'(u_if.o_busy), 32'd1);
        check_eq("a5_oe_after_load", 32'(sda_oe), 32'd1);
        check_eq("a5_msb_after_load", 32'(sda_out), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_byte(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 9, 1'b0, seen, oe9, out9);
        check_eq("a5_bus_bits", 32'(seen[8:1]), 32'hA5);
        check_eq("a5_ack_bit", 32'(seen[0]), 32'd0);
        check_eq("a5_oe9", 32'(oe9), 32'd0);
        check_eq("a5_done_pulses", 32'(n_done - base), 32'd1);
        check_eq("a5_ack_rcv", 32'(u_if.o_ack_received), 32'd1);
        check_eq("a5_busy_at_done", 32'(busy_at_done), 32'd0);
        check_eq("a5_cnt", 32'(u_if.o_bit_cnt), 32'd8);

        // TX 0xFF, no ACK
        base = n_done;
        run_byte(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 9, 1'b0, seen, oe9, out9);
        check_eq("ff_bus_bits", 32'(seen[8:1]), 32'hFF);
        check_eq("ff_done_pulses", 32'(n_done - base), 32'd1);
        check_eq("ff_ack_rcv", 32'(u_if.o_ack_received), 32'd0);

        // RX 0x3C, we ACK
        base = n_done;
        run_byte(1'b1, 8'h00, 1'b1, 8'h3C, 1'b1, 9, 1'b0, seen, oe9, out9);
        check_eq("3c_oe9", 32'(oe9), 32'd1);
        check_eq("3c_out9", 32'(out9), 32'd0);
        check_eq("3c_ack_bit", 32'(seen[0]), 32'd0);
        check_eq("3c_rx_data", 32'(u_if.o_rx_data), 32'h3C);
        check_eq("3c_ack_rcv", 32'(u_if.o_ack_received), 32'd1);
        check_eq("3c_done_pulses", 32'(n_done - base), 32'd1);

        // RX 0x81, we NACK
        base = n_done;
        run_byte(1'b1, 8'h00, 1'b0, 8'h81, 1'b1, 9, 1'b0, seen, oe9, out9);
        check_eq("81_oe9", 32'(oe9), 32'd1);
        check_eq("81_out9", 32'(out9), 32'd1);
        check_eq("81_rx_data", 32'(u_if.o_rx_data), 32'h81);
        check_eq("81_ack_rcv", 32'(u_if.o_ack_received), 32'd0);

        // TX 0x55 with an ignored reload of 0x00 after 3 bits
        base = n_done;
        run_byte(1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 9, 1'b1, seen, oe9, out9);
        check_eq("55_bus_bits", 32'(seen[8:1]), 32'h55);
        check_eq("55_done_pulses", 32'(n_done - base), 32'd1);
        check_eq("55_ack_rcv", 32'(u_if.o_ack_received), 32'd1);

        // Abort via i_shift_en after 4 bits of an RX byte
        base = n_done;
        run_byte(1'b1, 8'h00, 1'b1, 8'hF0, 1'b1, 4, 1'b0, seen, oe9, out9);
        check_eq("abort_cnt_before", 32'(u_if.o_bit_cnt), 32'd4);
        u_if.i_shift_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_oe", 32'(sda_oe), 32'd0);
        check_eq("abort_busy", 32'(u_if.o_busy), 32'd0);
        check_eq("abort_cnt", 32'(u_if.o_bit_cnt), 32'd0);
        check_eq("abort_rx_kept", 32'(u_if.o_rx_data), 32'h81);
        check_eq("abort_ack_kept", 32'(u_if.o_ack_received), 32'd1);
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", 32'(n_done - base), 32'd0);
        u_if.i_shift_en = 1'b1;

        // Reset after 5 bits of a TX byte
        run_byte(1'b0, 8'h0F, 1'b0, 8'h00, 1'b0, 5, 1'b0, seen, oe9, out9);
        check_eq("rstmid_busy_before", 32'(u_if.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_oe", 32'(sda_oe), 32'd0);
        check_eq("rstmid_out", 32'(sda_out), 32'd1);
        check_eq("rstmid_busy", 32'(u_if.o_busy), 32'd0);
        check_eq("rstmid_cnt", 32'(u_if.o_bit_cnt), 32'd0);
        check_eq("rstmid_rx", 32'(u_if.o_rx_data), 32'h00);
        check_eq("rstmid_ack", 32'(u_if.o_ack_received), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Recovery: TX 0x12 with ACK
        base = n_done;
        run_byte(1'b0, 8'h12, 1'b0, 8'h00, 1'b0, 9, 1'b0, seen, oe9, out9);
        check_eq("12_bus_bits", 32'(seen[8:1]), 32'h12);
        check_eq("12_oe9", 32'(oe9), 32'd0);
        check_eq("12_done_pulses", 32'(n_done - base), 32'd1);
        check_eq("12_ack_rcv", 32'(u_if.o_ack_received), 32'd1);
        check_eq("12_busy", 32'(u_if.o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
